// File: rtl/jtframe_mouse_sched.sv
// jtframe_mouse_sched
// Frame scheduler placed in front of jtframe_mouse. Bursty mouse events are
// summed per player, the sums are frozen on the LVBL falling edge, and the
// frozen values are replayed as at most two strobes: P0 first, then P1 after
// GAP idle cycles. Games therefore see one motion update per frame.
//
// Build option: define JTFRAME_MOUSE_SAT_EN to make the accumulators
// saturate and to clamp the 9-bit outputs. Without it the accumulators wrap
// and the outputs are the low 9 bits of the sum.

module jtframe_mouse_sched #(
  parameter int ACCW = 12,
  parameter int GAP  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lvbl,
  input  logic       lock,
  input  logic [8:0] mouse_dx,
  input  logic [8:0] mouse_dy,
  input  logic [7:0] mouse_f,
  input  logic       mouse_st,
  input  logic       mouse_idx,
  output logic [8:0] out_dx,
  output logic [8:0] out_dy,
  output logic [7:0] out_f,
  output logic       out_st,
  output logic       out_idx
);

  // Gap counter only has to hold GAP-1
  localparam int CW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP - 1);

`ifdef JTFRAME_MOUSE_SAT_EN
  localparam logic signed [ACCW:0]   SAT_POS = (ACCW+1)'((2**(ACCW-1)) - 1);
  localparam logic signed [ACCW:0]   SAT_NEG = -SAT_POS;
  localparam logic signed [ACCW-1:0] OUT_MAX = ACCW'(255);
  localparam logic signed [ACCW-1:0] OUT_MIN = ACCW'(-256);
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    S0   = 2'd1,
    GAPW = 2'd2,
    S1   = 2'd3
  } state_t;

  state_t         state_reg, state_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic           lvbl_l_reg;
  logic           tick;
  logic           sel;

  // Values held on the outputs between strobes
  logic [8:0]     dx_hold_reg, dy_hold_reg;
  logic [7:0]     f_hold_reg;
  logic           idx_hold_reg;

  // Per-player frozen frame values, flattened for the replay mux
  logic [1:0][8:0] snap_dx, snap_dy;
  logic [1:0][7:0] snap_f;
  logic [1:0]      snap_pend;

  // Sign-extend a 9-bit event delta to accumulator width
  function automatic logic signed [ACCW-1:0] sext(input logic signed [8:0] d);
    return ACCW'(d);
  endfunction

  // Add one event delta to an accumulator
  function automatic logic signed [ACCW-1:0] acc_add(
    input logic signed [ACCW-1:0] a,
    input logic signed [8:0]      d
  );
`ifdef JTFRAME_MOUSE_SAT_EN
    logic signed [ACCW:0] s;
    s = (ACCW+1)'(a) + (ACCW+1)'(d);
    if (s > SAT_POS)
      return SAT_POS[ACCW-1:0];
    else if (s < SAT_NEG)
      return SAT_NEG[ACCW-1:0];
    else
      return s[ACCW-1:0];
`else
    return a + sext(d);
`endif
  endfunction

  // Reduce an accumulator to the 9-bit delta sent to jtframe_mouse
  function automatic logic [8:0] narrow(input logic signed [ACCW-1:0] a);
`ifdef JTFRAME_MOUSE_SAT_EN
    if (a > OUT_MAX)
      return 9'h0FF;
    else if (a < OUT_MIN)
      return 9'h100;
    else
      return a[8:0];
`else
    return a[8:0];
`endif
  endfunction

  // Frame tick: LVBL falling edge, only when unlocked and not already sending
  assign tick = lvbl_l_reg & ~lvbl & ~lock & (state_reg == IDLE);

  // Delayed copy of LVBL for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      lvbl_l_reg <= 1'b1;
    else
      lvbl_l_reg <= lvbl;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gen_player
      logic signed [ACCW-1:0] acc_x_reg, acc_y_reg;
      logic [7:0]             flg_reg;
      logic                   pend_reg;
      logic [8:0]             snap_dx_reg, snap_dy_reg;
      logic [7:0]             snap_f_reg;
      logic                   snap_pend_reg;
      logic                   hit;

      assign hit = mouse_st & (mouse_idx == 1'(gi));

      // Accumulate events; on a tick freeze the frame and restart the sum,
      // seeding it with any event arriving in the tick cycle itself
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          acc_x_reg     <= '0;
          acc_y_reg     <= '0;
          flg_reg       <= '0;
          pend_reg      <= 1'b0;
          snap_dx_reg   <= '0;
          snap_dy_reg   <= '0;
          snap_f_reg    <= '0;
          snap_pend_reg <= 1'b0;
        end else begin
          if (tick) begin
            snap_dx_reg   <= narrow(acc_x_reg);
            snap_dy_reg   <= narrow(acc_y_reg);
            snap_f_reg    <= flg_reg;
            snap_pend_reg <= pend_reg;
            acc_x_reg     <= hit ? sext(mouse_dx) : '0;
            acc_y_reg     <= hit ? sext(mouse_dy) : '0;
            pend_reg      <= hit;
          end else if (hit) begin
            acc_x_reg     <= acc_add(acc_x_reg, mouse_dx);
            acc_y_reg     <= acc_add(acc_y_reg, mouse_dy);
            pend_reg      <= 1'b1;
          end
          if (hit)
            flg_reg <= mouse_f;
        end
      end

      assign snap_dx[gi]   = snap_dx_reg;
      assign snap_dy[gi]   = snap_dy_reg;
      assign snap_f[gi]    = snap_f_reg;
      assign snap_pend[gi] = snap_pend_reg;
    end
  endgenerate

  // Replay sequencer state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next state and strobe outputs; data come straight from the frozen
  // snapshot during a strobe and from the hold registers otherwise
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    out_st     = 1'b0;
    sel        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (tick)
          state_next = S0;
      end
      S0: begin
        out_st     = snap_pend[0];
        state_next = GAPW;
        cnt_next   = GAP_LAST;
      end
      GAPW: begin
        if (cnt_reg == '0)
          state_next = S1;
        else
          cnt_next = cnt_reg - 1'b1;
      end
      S1: begin
        out_st     = snap_pend[1];
        sel        = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    out_dx  = out_st ? snap_dx[sel] : dx_hold_reg;
    out_dy  = out_st ? snap_dy[sel] : dy_hold_reg;
    out_f   = out_st ? snap_f[sel]  : f_hold_reg;
    out_idx = out_st ? sel          : idx_hold_reg;
  end

  // Keep the last strobe's values on the outputs until the next strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dx_hold_reg  <= '0;
      dy_hold_reg  <= '0;
      f_hold_reg   <= '0;
      idx_hold_reg <= 1'b0;
    end else if (out_st) begin
      dx_hold_reg  <= out_dx;
      dy_hold_reg  <= out_dy;
      f_hold_reg   <= out_f;
      idx_hold_reg <= out_idx;
    end
  end

endmodule

// File: tb/tb_jtframe_mouse_sched.sv
// Bench for jtframe_mouse_sched: a frame-level model predicts every strobe
// (cycle, player, deltas, flags) and the outputs are compared every cycle;
// literal values from the directed scenarios pin the model.

module tb_jtframe_mouse_sched;

  localparam int ACCW = 12;
  localparam int GAP  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       lvbl = 1'b1;
  logic       lock = 1'b0;
  logic [8:0] mouse_dx = '0;
  logic [8:0] mouse_dy = '0;
  logic [7:0] mouse_f = '0;
  logic       mouse_st = 1'b0;
  logic       mouse_idx = 1'b0;
  logic [8:0] out_dx, out_dy;
  logic [7:0] out_f;
  logic       out_st, out_idx;

  jtframe_mouse_sched #(.ACCW(ACCW), .GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .lvbl(lvbl), .lock(lock),
    .mouse_dx(mouse_dx), .mouse_dy(mouse_dy), .mouse_f(mouse_f),
    .mouse_st(mouse_st), .mouse_idx(mouse_idx),
    .out_dx(out_dx), .out_dy(out_dy), .out_f(out_f),
    .out_st(out_st), .out_idx(out_idx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int         cyc;
    bit         idx;
    logic [8:0] dx;
    logic [8:0] dy;
    logic [7:0] f;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   m_acc_x[2] = '{0, 0};
  int   m_acc_y[2] = '{0, 0};
  bit   m_pend[2] = '{0, 0};
  logic [7:0] m_flg[2] = '{8'h00, 8'h00};
  bit   m_prev_lvbl = 1'b1;
  int   m_last_tick = -100;
  logic [8:0] h_dx = '0, h_dy = '0;
  logic [7:0] h_f = '0;

  function automatic int madd(int a, int d);
`ifdef JTFRAME_MOUSE_SAT_EN
    int s = a + d;
    int lim = (1 << (ACCW - 1)) - 1;
    if (s > lim) return lim;
    if (s < -lim) return -lim;
    return s;
`else
    return a + d;   // wrap is invisible in the low 9 bits
`endif
  endfunction

  function automatic logic [8:0] mnar(int a);
    int v = a;
`ifdef JTFRAME_MOUSE_SAT_EN
    if (v > 255) v = 255;
    if (v < -256) v = -256;
`endif
    return 9'(v);
  endfunction

  always @(negedge rst_n) begin
    q.delete();
    m_acc_x = '{0, 0};
    m_acc_y = '{0, 0};
    m_pend = '{0, 0};
    m_flg = '{8'h00, 8'h00};
    m_prev_lvbl = 1'b1;
    m_last_tick = -100;
    h_dx = '0; h_dy = '0; h_f = '0;
  end

  // Model step: inputs of cycle 'cyc' are consumed at the edge ending it
  always @(posedge clk) begin
    if (rst_n) begin
      bit busy_free, tk;
      exp_t e;
      busy_free = (cyc >= m_last_tick + GAP + 3);
      tk = m_prev_lvbl && !lvbl && !lock && busy_free;
      if (tk) begin
        m_last_tick = cyc;
        for (int p = 0; p < 2; p++) begin
          if (m_pend[p]) begin
            e.cyc = cyc + ((p == 0) ? 1 : GAP + 2);
            e.idx = 1'(p);
            e.dx  = mnar(m_acc_x[p]);
            e.dy  = mnar(m_acc_y[p]);
            e.f   = m_flg[p];
            q.push_back(e);
          end
          m_acc_x[p] = 0;
          m_acc_y[p] = 0;
          m_pend[p]  = 1'b0;
        end
      end
      if (mouse_st) begin
        m_acc_x[mouse_idx] = madd(m_acc_x[mouse_idx], int'($signed(mouse_dx)));
        m_acc_y[mouse_idx] = madd(m_acc_y[mouse_idx], int'($signed(mouse_dy)));
        m_flg[mouse_idx]   = mouse_f;
        m_pend[mouse_idx]  = 1'b1;
      end
      m_prev_lvbl = lvbl;
    end
    cyc++;
  end

  // Strobe log used by the literal checks
  int         n_str = 0;
  logic [8:0] last_dx = '0, last_dy = '0, prev_dx = '0;
  logic [7:0] last_f = '0;
  logic       last_idx = 1'b0;
  int         last_cyc = 0, prev_cyc = 0;

  // Compare process: every cycle, mid-period
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_outs", {23'd0, out_st, out_idx, out_dx, out_dy, out_f}, 32'd0);
    end else begin
      if (q.size() > 0 && q[0].cyc == cyc) begin
        exp_t e;
        e = q.pop_front();
        chk("strobe", {4'd0, out_st, out_idx, out_dx, out_dy, out_f},
            {4'd0, 1'b1, e.idx, e.dx, e.dy, e.f});
        h_dx = e.dx; h_dy = e.dy; h_f = e.f;
      end else begin
        chk("quiet", {5'd0, out_st, out_dx, out_dy, out_f},
            {5'd0, 1'b0, h_dx, h_dy, h_f});
      end
      if (out_st) begin
        n_str++;
        prev_dx = last_dx; prev_cyc = last_cyc;
        last_dx = out_dx; last_dy = out_dy; last_f = out_f;
        last_idx = out_idx; last_cyc = cyc;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc_n(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ev(bit idx, int dx, int dy, logic [7:0] f);
    mouse_st = 1'b1; mouse_idx = idx;
    mouse_dx = 9'(dx); mouse_dy = 9'(dy); mouse_f = f;
    cyc_n(1);
    mouse_st = 1'b0;
  endtask

  task automatic frame();
    lvbl = 1'b0;
    cyc_n(8);
    lvbl = 1'b1;
    cyc_n(2);
  endtask

  int n0;

  initial begin
    cyc_n(3);
    chk("reset_out_dx", {23'd0, out_dx}, 32'd0);
    rst_n = 1'b1;
    cyc_n(2);

    // 1: accumulate across one frame
    n0 = n_str;
    ev(0, 10, 1, 8'h00);
    ev(0, 20, 1, 8'h00);
    ev(0, -5, 1, 8'h00);
    frame();
    chk("t1_count", n_str - n0, 1);
    chk("t1_idx", {31'd0, last_idx}, 0);
    chk("t1_dx", {23'd0, last_dx}, 25);
    chk("t1_dy", {23'd0, last_dy}, 3);

    // 2: both players
    n0 = n_str;
    ev(0, 4, 0, 8'h01);
    ev(1, -7, 0, 8'h05);
    frame();
    chk("t2_count", n_str - n0, 2);
    chk("t2_p0_dx", {23'd0, prev_dx}, 4);
    chk("t2_idx", {31'd0, last_idx}, 1);
    chk("t2_dx", {23'd0, last_dx}, 32'h1F9);
    chk("t2_f", {24'd0, last_f}, 32'h05);
    chk("t2_spacing", last_cyc - prev_cyc, 3);

    // 3: lock
    n0 = n_str;
    lock = 1'b1;
    repeat (4) ev(0, 3, 0, 8'h00);
    frame();
    frame();
    chk("t3_locked", n_str - n0, 0);
    lock = 1'b0;
    frame();
    chk("t3_count", n_str - n0, 1);
    chk("t3_dx", {23'd0, last_dx}, 12);

    // 4: large accumulation
    repeat (20) ev(0, 255, 0, 8'h00);
    frame();
`ifdef JTFRAME_MOUSE_SAT_EN
    chk("t4_dx", {23'd0, last_dx}, 255);
`else
    chk("t4_dx", {23'd0, last_dx}, 32'h1EC);
`endif

    // 5: event in the tick cycle goes to the next frame
    ev(0, 5, 0, 8'h00);
    lvbl = 1'b0;
    mouse_st = 1'b1; mouse_idx = 1'b0; mouse_dx = 9'd9; mouse_dy = 9'd0;
    cyc_n(1);
    mouse_st = 1'b0;
    cyc_n(7);
    lvbl = 1'b1;
    cyc_n(2);
    chk("t5_dx_a", {23'd0, last_dx}, 5);
    frame();
    chk("t5_dx_b", {23'd0, last_dx}, 9);

    // 6: reset in the gap
    ev(0, 2, 0, 8'h11);
    ev(1, 3, 0, 8'h22);
    lvbl = 1'b0;
    cyc_n(2);                       // now in the gap after the P0 strobe
    chk("t6_p0_dx", {23'd0, last_dx}, 2);
    rst_n = 1'b0;
    #1;
    chk("t6_async_outs", {14'd0, out_st, out_dx, out_f}, 32'd0);
    cyc_n(1);
    lvbl = 1'b1;
    cyc_n(2);
    rst_n = 1'b1;
    cyc_n(1);
    n0 = n_str;
    ev(0, 6, 0, 8'h00);
    frame();
    chk("t6_count", n_str - n0, 1);
    chk("t6_dx", {23'd0, last_dx}, 6);
    chk("t6_idx", {31'd0, last_idx}, 0);

    cyc_n(4);
    chk("pending_strobes", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
